bmem_burst_responder: RTL and testbench

//  Memory-side end of the bmem burst interface: answers the line requests that the

---
 rtl/bmem_burst_responder.sv | 173 +++++++++++++++++
 tb/tb_bmem_burst_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_burst_responder.sv
// Memory-side responder for the bmem burst interface: 4-beat line reads through an
// in-order outstanding-read queue, 4-beat line writes, backed by a 64-bit word array.
module bmem_burst_responder #(
  parameter int unsigned MEM_WORDS    = 256,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned RQ_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(RQ_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StBeat0,
    StBeat1,
    StBeat2,
    StBeat3
  } state_e;

  state_e state_q, state_d;

  logic [63:0] mem [MEM_WORDS];

  logic [31:0]   rq_addr_q [RQ_DEPTH];
  logic [15:0]   rq_due_q  [RQ_DEPTH];
  logic [PW-1:0] rq_rptr_q, rq_wptr_q;
  logic [PW:0]   rq_cnt_q, rq_cnt_d;
  logic [15:0]   cyc_q;

  logic [1:0]    wr_cnt_q, wr_cnt_d;
  logic [IW-1:0] wr_base_q;

  logic          rq_full, rq_empty, idle_empty;
  logic          head_elapsed, next_elapsed;
  logic          push, pop;
  logic          wr_fire0, wr_fire_n, mem_we;
  logic [IW-1:0] mem_widx, rd_idx;
  logic [1:0]    beat;
  logic [31:0]   line_addr;
  logic [31:0]   head_addr;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^bmem_addr[4:0];
  assign line_addr        = {bmem_addr[31:5], 5'b0};

  // Wrap-safe "due time reached" test against the free-running cycle counter.
  function automatic logic elapsed(input logic [15:0] now, input logic [15:0] due);
    logic [15:0] diff;
    diff = now - due;
    return !diff[15];
  endfunction

  assign rq_full    = (rq_cnt_q == (PW+1)'(RQ_DEPTH));
  assign rq_empty   = (rq_cnt_q == '0);
  assign idle_empty = rq_empty && (state_q == StIdle);
  assign head_addr  = rq_addr_q[rq_rptr_q];

  assign head_elapsed = !rq_empty && elapsed(cyc_q, rq_due_q[rq_rptr_q]);
  assign next_elapsed = elapsed(cyc_q, rq_due_q[rq_rptr_q + PW'(1)]);

  // A write may only start on a quiet read side; while it is held off, ready stays low.
  assign bmem_ready = rst && !rq_full && (wr_cnt_q == 2'd0) && !(bmem_write && !idle_empty);

  assign push      = bmem_read && bmem_ready && !bmem_write;
  assign wr_fire0  = bmem_write && bmem_ready;
  assign wr_fire_n = bmem_write && (wr_cnt_q != 2'd0);
  assign mem_we    = wr_fire0 || wr_fire_n;
  assign mem_widx  = wr_fire0 ? {bmem_addr[IW+2:5], 2'b00} : wr_base_q + IW'(wr_cnt_q);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_fire0) begin
      wr_cnt_d = 2'd1;
    end else if (wr_fire_n) begin
      wr_cnt_d = wr_cnt_q + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle:  if (!rq_empty) state_d = head_elapsed ? StBeat0 : StWait;
      StWait:  if (head_elapsed) state_d = StBeat0;
      StBeat0: state_d = StBeat1;
      StBeat1: state_d = StBeat2;
      StBeat2: state_d = StBeat3;
      StBeat3: begin
        pop = 1'b1;
        // With only the head left, go through Idle so a same-cycle push is seen there.
        if (rq_cnt_q > (PW+1)'(1)) begin
          state_d = next_elapsed ? StBeat0 : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rq_cnt_d = rq_cnt_q;
    if (push && !pop) begin
      rq_cnt_d = rq_cnt_q + (PW+1)'(1);
    end else if (!push && pop) begin
      rq_cnt_d = rq_cnt_q - (PW+1)'(1);
    end
  end

  always_comb begin
    bmem_rvalid = 1'b0;
    beat        = 2'd0;
    unique case (state_q)
      StBeat0: begin bmem_rvalid = 1'b1; beat = 2'd0; end
      StBeat1: begin bmem_rvalid = 1'b1; beat = 2'd1; end
      StBeat2: begin bmem_rvalid = 1'b1; beat = 2'd2; end
      StBeat3: begin bmem_rvalid = 1'b1; beat = 2'd3; end
      default: begin bmem_rvalid = 1'b0; beat = 2'd0; end
    endcase
  end

  assign rd_idx     = {head_addr[IW+2:5], 2'b00} + IW'(beat);
  assign bmem_rdata = bmem_rvalid ? mem[rd_idx] : 64'd0;
  assign bmem_raddr = bmem_rvalid ? head_addr : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rq_rptr_q <= '0;
      rq_wptr_q <= '0;
      rq_cnt_q  <= '0;
      cyc_q     <= '0;
      wr_cnt_q  <= 2'd0;
      wr_base_q <= '0;
    end else begin
      state_q  <= state_d;
      rq_cnt_q <= rq_cnt_d;
      cyc_q    <= cyc_q + 16'd1;
      wr_cnt_q <= wr_cnt_d;
      if (push) rq_wptr_q <= rq_wptr_q + PW'(1);
      if (pop)  rq_rptr_q <= rq_rptr_q + PW'(1);
      if (wr_fire0) wr_base_q <= {bmem_addr[IW+2:5], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rq_addr_q[rq_wptr_q] <= line_addr;
      rq_due_q[rq_wptr_q]  <= cyc_q + 16'(READ_LATENCY);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= bmem_wdata;
  end

  read_write_collide: assert property (@(posedge clk) disable iff (!rst)
      !(bmem_read && bmem_write && bmem_ready))
    else $error("bmem_read and bmem_write asserted together; read dropped");

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Scoreboard bench for bmem_burst_responder: a reference word array predicts every read
// beat at accept time; a negedge monitor pops and compares returned beats in order.
module tb_bmem_burst_responder;

  localparam int unsigned MemWords = 256;
  localparam int unsigned ReadLat  = 4;
  localparam logic [63:0] BeatStep = 64'h1111_1111_1111_1111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  bmem_burst_responder #(
    .MEM_WORDS   (MemWords),
    .READ_LATENCY(ReadLat),
    .RQ_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] mem_m [MemWords];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input int i);
    logic [31:0] w;
    w = ({a[31:5], 5'b0} >> 3) + 32'(i);
    return int'(w % MemWords);
  endfunction

  always @(negedge clk) begin
    if (rst && bmem_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("rdata", bmem_rdata, e.data);
        check("raddr", {32'd0, bmem_raddr}, {32'd0, e.addr});
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 of the accept edge.
  task automatic do_read(input logic [31:0] a, output int waits, output int acc_cyc);
    waits     = 0;
    acc_cyc   = -1;
    bmem_addr = a;
    bmem_read = 1'b1;
    @(negedge clk);
    while (!bmem_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!bmem_ready) begin
      check("read_accept_timeout", 0, 1);
      bmem_read = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) sb.push_back('{addr: {a[31:5], 5'b0}, data: mem_m[widx(a, i)]});
    #1;
    acc_cyc   = cyc;
    bmem_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d0, input int stall);
    int t = 0;
    bmem_addr  = a;
    bmem_write = 1'b1;
    bmem_wdata = d0;
    @(negedge clk);
    while (!bmem_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("wr_accept", bmem_ready, 1);
    @(posedge clk);
    mem_m[widx(a, 0)] = d0;
    #1;
    bmem_addr = 32'hDEAD_BEEF;
    for (int k = 1; k < 4; k++) begin
      if (k == 2) begin
        for (int s = 0; s < stall; s++) begin
          bmem_write = 1'b0;
          bmem_wdata = '1;
          @(negedge clk);
          check("wr_stall_ready", bmem_ready, 0);
          @(posedge clk);
          #1;
        end
      end
      bmem_write = 1'b1;
      bmem_wdata = d0 + BeatStep * 64'(k);
      @(negedge clk);
      check("wr_beat_ready", bmem_ready, 0);
      @(posedge clk);
      mem_m[widx(a, k)] = d0 + BeatStep * 64'(k);
      #1;
    end
    bmem_write = 1'b0;
    @(negedge clk);
    check("wr_done_ready", bmem_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bmem_rvalid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(output int t);
    t = 0;
    @(negedge clk);
    while (!bmem_rvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rvalid_seen", bmem_rvalid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, acc, t, run;
    logic [31:0] a6;

    // Reset state
    #12;
    check("rst_ready", bmem_ready, 0);
    check("rst_rvalid", bmem_rvalid, 0);
    check("rst_rdata", bmem_rdata, 0);
    check("rst_raddr", {32'd0, bmem_raddr}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bmem_ready, 1);
    @(posedge clk);
    #1;

    // T2: write then read, exact latency
    do_write(32'h2000, 64'h5555_5555_5555_5555, 0);
    do_read(32'h2000, w, acc);
    wait_rvalid(t);
    check("t2_latency", 64'(cyc - acc), 64'(ReadLat));
    drain();

    // T1: reset mid-burst
    do_read(32'h2000, w, acc);
    wait_rvalid(t);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t1_rvalid", bmem_rvalid, 0);
    check("t1_rdata", bmem_rdata, 0);
    check("t1_ready", bmem_ready, 0);
    check("t1_raddr", {32'd0, bmem_raddr}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t1_ready_release", bmem_ready, 1);
    run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bmem_rvalid) run++;
    end
    check("t1_no_resume", 64'(run), 0);
    @(posedge clk);
    #1;

    // T3: pipelined reads stream contiguously
    for (int j = 0; j < 4; j++) begin
      do_write(32'h1000 + 32'(j * 32), {32'hA000_0000 + 32'(j), 32'h0000_0100}, 0);
    end
    for (int j = 0; j < 4; j++) begin
      do_read(32'h1000 + 32'(j * 32), w, acc);
      check("t3_wait", 64'(w), 0);
    end
    wait_rvalid(t);
    run = 0;
    while (bmem_rvalid && run < 40) begin
      run++;
      @(negedge clk);
    end
    check("t3_contig", 64'(run), 16);
    drain();

    // T4: queue full holds off the 5th read until the first pop
    for (int j = 0; j < 4; j++) do_read(32'h1060 - 32'(j * 32), w, acc);
    do_read(32'h2000, w, acc);
    check("t4_full_wait", 64'(w), 5);
    drain();

    // Write held off while reads are outstanding
    do_read(32'h1020, w, acc);
    bmem_addr  = 32'h0200;
    bmem_write = 1'b1;
    @(negedge clk);
    check("wr_blocked", bmem_ready, 0);
    @(posedge clk);
    #1;
    bmem_write = 1'b0;
    drain();

    // T5: write stall between beats
    do_write(32'h0200, 64'hC0DE_0000_0000_0001, 2);
    do_read(32'h0200, w, acc);
    drain();

    // T6: top-of-array line, unaligned and high address bits
    a6 = (MemWords * 8 - 16) | 32'h1F;
    do_write(a6, 64'h0123_4567_89AB_CDEF, 0);
    do_read(a6, w, acc);
    drain();
    do_read(32'hFFFF_FFFF, w, acc);
    drain();
    do_read(32'h0000_001F, w, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
